uart_echo_responder: RTL and testbench
======================================

# uart_echo_responder

User-side responder for the `uart` transceiver: consumes bytes the UART reports as received, buffers them in a small FIFO, and replays each one to the UART transmit interface, so a remote initiator sees every byte echoed back. It connects directly to the `uart` byte-side ports (`received`/`rx_byte`/`recv_error` in, `transmit`/`tx_byte` out, `is_transmitting` as back-pressure). It is the standard on-board loopback target for link bring-up.

## Interface
- `DEPTH`, 16: FIFO depth in bytes; power of two, at least 2.
- `ERR_ECHO`, 1: 1 = a `recv_error` pulse enqueues `ERR_BYTE`; 0 = the error is only counted.
- `ERR_BYTE`, 8'h3F: substitute byte for a framing error.
- `BUSY_TIMEOUT`, 8: cycles to wait for `is_transmitting` to rise after a `transmit` pulse.

Ports:
- `clk`  in  1  single clock, shared with `uart`.
- `rst`  in  1  synchronous, active-high reset.
- `received`  in  1  one-cycle pulse; `rx_byte` is valid in that cycle.
- `rx_byte`  in  8  received byte.
- `recv_error`  in  1  one-cycle pulse on a framing error.
- `is_transmitting`  in  1  UART TX busy.
- `transmit`  out  1  one-cycle pulse requesting transmission of `tx_byte`.
- `tx_byte`  out  8  registered byte to send; held stable until the next load.
- `fifo_count`  out  $clog2(DEPTH)+1  current occupancy.
- `overflow`  out  1  sticky; a byte was dropped because the FIFO was full.
- `err_count`  out  8  count of `recv_error` pulses; saturates at 255.

## Operation
- Push source:
  - `received` pushes `rx_byte`.
  - Otherwise `recv_error` with `ERR_ECHO`=1 pushes `ERR_BYTE`.
  - If both pulse in the same cycle, `rx_byte` wins and the error is only counted.
- FSM states: IDLE, SEND, WAIT_BUSY, WAIT_DONE.
  - IDLE: if the FIFO is not empty and `is_transmitting`=0, pop the head into `tx_byte` and go to SEND.
  - SEND: `transmit`=1 for exactly this cycle; go to WAIT_BUSY with the timeout counter cleared.
  - WAIT_BUSY: when `is_transmitting`=1, go to WAIT_DONE. If `BUSY_TIMEOUT` cycles elapse without it rising, go to IDLE; the byte counts as sent and is not retried.
  - WAIT_DONE: when `is_transmitting`=0, go to IDLE.
- FIFO:
  - Circular buffer; read/write pointers wrap modulo `DEPTH`.
  - Push while full: the byte is dropped and `overflow` is set.
  - Push and pop in the same cycle while full: the pop frees a slot, so the push is accepted and the count is unchanged.
  - Push and pop in the same cycle while empty cannot happen, because a pop requires non-empty in IDLE.
- `err_count` increments on every `recv_error`, whatever `ERR_ECHO` is set to.

## Timing
- Reset values: `transmit`=0, `tx_byte`=8'h00, `fifo_count`=0, `overflow`=0, `err_count`=0, FSM in IDLE, pointers 0.
- Latency with the FIFO empty and the UART idle:
  - `received` high in cycle N.
  - `fifo_count`=1 in cycle N+1, when IDLE pops.
  - `transmit`=1 and the new `tx_byte` in cycle N+2.
- `tx_byte` changes only on the edge that enters SEND, so it is stable whenever `transmit`=1.
- Back-to-back: the next `transmit` comes no earlier than 2 cycles after `is_transmitting` falls (WAIT_DONE→IDLE, IDLE→SEND).
- Reset mid-operation:
  - The FIFO is flushed and any byte in flight is abandoned.
  - If the UART is still sending, IDLE holds off until `is_transmitting`=0.
- `fifo_count` and `overflow` update on the edge after the causing push/pop.

## Structure
- Shared package `uart_pkg`:
  - FSM state enum.
  - `ERR_BYTE` default.
  - Byte-width constant `UART_DW`=8, also used by `uart`.
- Sub-module `uart_byte_fifo`:
  - Parameterised by `DEPTH`.
  - Ports: push, din, pop, dout, empty, full, count.
  - Synchronous reset; zero-latency head output (`dout` = head when not empty).
- Top-level contents: FSM, timeout counter, error counter, overflow flag.

## Test plan
- Single echo: after reset, pulse `received` with `rx_byte`=8'hCC at cycle N → `transmit` pulse at N+2 with `tx_byte`=8'hCC. Model the UART as raising `is_transmitting` 1 cycle later for 20 cycles → exactly one `transmit`.
- Burst ordering: push 8'h01..8'h05 on consecutive cycles while `is_transmitting` is held high → `fifo_count` reaches 5. Release busy → five `transmit` pulses carrying 01..05 in order, each after the previous busy period ends.
- Overflow: with `DEPTH`=16, push 17 bytes while busy → count 16 and `overflow`=1. The echoed sequence is the first 16 bytes; the 17th is never sent.
- Error handling: a `recv_error` pulse with `ERR_ECHO`=1 → `tx_byte`=8'h3F echoed and `err_count`=1. Same-cycle `received`(8'hA5) + `recv_error` → only A5 is echoed and `err_count`=2.
- Timeout: `is_transmitting` never rises → FSM back in IDLE after SEND plus 8 cycles, and the next queued byte is sent.
- Reset mid-transfer: `rst` while in WAIT_DONE with 3 bytes queued → all outputs at reset values on the next cycle, and nothing is echoed afterwards.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the uart transceiver and its byte-side clients.
package uart_pkg;

  localparam int UART_DW = 8;
  localparam logic [UART_DW-1:0] ERR_BYTE_DEF = 8'h3F;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_SEND      = 2'd1,
    ST_WAIT_BUSY = 2'd2,
    ST_WAIT_DONE = 2'd3
  } state_e;

endpackage

// File: rtl/uart_byte_fifo.sv
// Circular byte FIFO with zero-latency head output; a push while full is
// accepted only when a pop frees the slot in the same cycle.
module uart_byte_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push,
  input  logic [UART_DW-1:0] din,
  input  logic               pop,
  output logic [UART_DW-1:0] dout,
  output logic               empty,
  output logic               full,
  output logic [CW-1:0]      count
);

  logic [UART_DW-1:0] mem [DEPTH];
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic               do_push;
  logic               do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/uart_echo_responder.sv
// Loopback responder: queues bytes received by the UART and replays each one
// on the UART transmit interface, honouring is_transmitting as back-pressure.
module uart_echo_responder
  import uart_pkg::*;
#(
  parameter int                 DEPTH        = 16,
  parameter bit                 ERR_ECHO     = 1'b1,
  parameter logic [UART_DW-1:0] ERR_BYTE     = ERR_BYTE_DEF,
  parameter int                 BUSY_TIMEOUT = 8,
  localparam int CW = $clog2(DEPTH) + 1,
  localparam int TW = $clog2(BUSY_TIMEOUT + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               received,
  input  logic [UART_DW-1:0] rx_byte,
  input  logic               recv_error,
  input  logic               is_transmitting,
  output logic               transmit,
  output logic [UART_DW-1:0] tx_byte,
  output logic [CW-1:0]      fifo_count,
  output logic               overflow,
  output logic [7:0]         err_count
);

  state_e             state;
  logic [TW-1:0]      tmo_cnt;
  logic               push;
  logic [UART_DW-1:0] push_data;
  logic               pop;
  logic [UART_DW-1:0] head;
  logic               empty;
  logic               full;

  // A real byte always wins over a same-cycle framing error.
  assign push      = received || (recv_error && ERR_ECHO);
  assign push_data = received ? rx_byte : ERR_BYTE;
  assign pop       = (state == ST_IDLE) && !empty && !is_transmitting;
  assign transmit  = (state == ST_SEND);

  uart_byte_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (push_data),
    .pop   (pop),
    .dout  (head),
    .empty (empty),
    .full  (full),
    .count (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      tmo_cnt   <= '0;
      tx_byte   <= '0;
      overflow  <= 1'b0;
      err_count <= '0;
    end else begin
      if (push && full && !pop) overflow <= 1'b1;
      if (recv_error && (err_count != 8'hFF)) err_count <= err_count + 8'd1;

      case (state)
        ST_IDLE: begin
          if (pop) begin
            tx_byte <= head;
            state   <= ST_SEND;
          end
        end
        ST_SEND: begin
          tmo_cnt <= '0;
          state   <= ST_WAIT_BUSY;
        end
        // A UART that never reports busy must not stall the echo path forever.
        ST_WAIT_BUSY: begin
          if (is_transmitting) begin
            state <= ST_WAIT_DONE;
          end else if (tmo_cnt == TW'(BUSY_TIMEOUT - 1)) begin
            state <= ST_IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
          end
        end
        ST_WAIT_DONE: begin
          if (!is_transmitting) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_echo_responder.sv
// Directed bench for uart_echo_responder with a behavioural UART busy model
// and a byte scoreboard checked on every transmit pulse.
module tb_uart_echo_responder;

  localparam int TMO = 8;
  localparam int BUSY_LEN = 20;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       received = 1'b0;
  logic [7:0] rx_byte = 8'h00;
  logic       recv_error = 1'b0;
  logic       is_transmitting;
  logic       transmit;
  logic [7:0] tx_byte;
  logic [4:0] fifo_count;
  logic       overflow;
  logic [7:0] err_count;

  logic       hold_busy = 1'b0;
  logic       uart_en = 1'b1;
  int         busy_cnt = 0;
  int         cyc = 0;
  int         tx_total = 0;
  int         last_tx_cyc = 0;
  int         prev_tx_cyc = 0;
  int         n_cmp = 0;
  int         n_err = 0;
  logic [7:0] exp_q[$];

  uart_echo_responder #(
    .DEPTH        (16),
    .ERR_ECHO     (1'b1),
    .ERR_BYTE     (8'h3F),
    .BUSY_TIMEOUT (TMO)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .received        (received),
    .rx_byte         (rx_byte),
    .recv_error      (recv_error),
    .is_transmitting (is_transmitting),
    .transmit        (transmit),
    .tx_byte         (tx_byte),
    .fifo_count      (fifo_count),
    .overflow        (overflow),
    .err_count       (err_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // UART model: busy from the cycle after a transmit pulse for BUSY_LEN cycles.
  always @(posedge clk) begin
    if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
    else if (transmit && uart_en) busy_cnt <= BUSY_LEN;
  end
  assign is_transmitting = hold_busy || (busy_cnt != 0);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (transmit === 1'b1) begin
      tx_total++;
      prev_tx_cyc = last_tx_cyc;
      last_tx_cyc = cyc;
      chk("tx_while_busy", 32'(is_transmitting), 0);
      chk("tx_pending", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) chk("tx_byte", tx_byte, exp_q.pop_front());
    end
  end

  // Called at a negedge; drives one cycle of inputs and returns at the next negedge.
  task automatic pulse(input bit rcv, input logic [7:0] b, input bit err);
    received   = rcv;
    rx_byte    = b;
    recv_error = err;
    @(negedge clk);
    received   = 1'b0;
    recv_error = 1'b0;
  endtask

  task automatic settle(input string tag);
    bit done = 1'b0;
    for (int i = 0; i < 400 && !done; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !is_transmitting && fifo_count == 0 && !transmit) done = 1'b1;
    end
    chk({"settle_", tag}, 32'(done), 1);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    bit got;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_transmit", 32'(transmit), 0);
    chk("rst_tx_byte", tx_byte, 8'h00);
    chk("rst_count", fifo_count, 0);
    chk("rst_overflow", 32'(overflow), 0);
    chk("rst_err", err_count, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Single echo with exact latency
    exp_q.push_back(8'hCC);
    pulse(1'b1, 8'hCC, 1'b0);
    chk("single_count_n1", fifo_count, 1);
    chk("single_tx_n1", 32'(transmit), 0);
    @(negedge clk);
    chk("single_tx_n2", 32'(transmit), 1);
    chk("single_byte_n2", tx_byte, 8'hCC);
    settle("single");
    chk("single_total", tx_total, 1);

    // Burst ordering under back-pressure
    hold_busy = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      exp_q.push_back(8'(i));
      pulse(1'b1, 8'(i), 1'b0);
    end
    chk("burst_count", fifo_count, 5);
    chk("burst_no_tx", tx_total, 1);
    hold_busy = 1'b0;
    settle("burst");
    chk("burst_total", tx_total, 6);

    // Overflow: 17 pushes into 16 slots
    hold_busy = 1'b1;
    for (int i = 0; i < 17; i++) begin
      if (i < 16) exp_q.push_back(8'(8'h10 + i));
      pulse(1'b1, 8'(8'h10 + i), 1'b0);
    end
    chk("ovf_count", fifo_count, 16);
    chk("ovf_flag", 32'(overflow), 1);
    hold_busy = 1'b0;
    settle("ovf");
    chk("ovf_total", tx_total, 22);
    chk("ovf_sticky", 32'(overflow), 1);

    // Framing error echoes the substitute byte
    exp_q.push_back(8'h3F);
    pulse(1'b0, 8'h00, 1'b1);
    chk("err_count1", err_count, 1);
    settle("err1");
    exp_q.push_back(8'hA5);
    pulse(1'b1, 8'hA5, 1'b1);
    chk("err_count2", err_count, 2);
    chk("err_q_len", fifo_count, 1);
    settle("err2");
    chk("err_total", tx_total, 24);

    // Timeout: UART never raises busy
    uart_en = 1'b0;
    base = tx_total;
    exp_q.push_back(8'h55);
    exp_q.push_back(8'h66);
    pulse(1'b1, 8'h55, 1'b0);
    pulse(1'b1, 8'h66, 1'b0);
    got = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      if (tx_total == base + 2) got = 1'b1;
    end
    chk("tmo_both_sent", tx_total, base + 2);
    chk("tmo_gap", last_tx_cyc - prev_tx_cyc, TMO + 2);
    repeat (TMO + 4) @(negedge clk);
    uart_en = 1'b1;
    settle("tmo");

    // Reset while in WAIT_DONE with three bytes queued
    exp_q.push_back(8'h71);
    pulse(1'b1, 8'h71, 1'b0);
    pulse(1'b1, 8'h72, 1'b0);
    pulse(1'b1, 8'h73, 1'b0);
    pulse(1'b1, 8'h74, 1'b0);
    repeat (2) @(negedge clk);
    chk("mid_busy", 32'(is_transmitting), 1);
    chk("mid_queued", fifo_count, 3);
    base = tx_total;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_transmit", 32'(transmit), 0);
    chk("mid_rst_tx_byte", tx_byte, 8'h00);
    chk("mid_rst_count", fifo_count, 0);
    chk("mid_rst_overflow", 32'(overflow), 0);
    chk("mid_rst_err", err_count, 0);
    repeat (40) @(negedge clk);
    chk("mid_no_echo", tx_total, base);
    chk("mid_q_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
